// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key decoder: Set 2 scan codes, key bitmap
// indices and the byte-reader FSM state type.
package ps2_pkg;

  localparam int unsigned NKEYS = 11;
  localparam int unsigned IDX_W = 4;

  // Prefix, control and overrun bytes
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_EE = 8'hEE;
  localparam logic [7:0] SC_FE = 8'hFE;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;

  // Key make codes (the last four follow an E0 prefix)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Bit positions in the held-key bitmap
  localparam logic [IDX_W-1:0] KEY_W     = 4'd0;
  localparam logic [IDX_W-1:0] KEY_A     = 4'd1;
  localparam logic [IDX_W-1:0] KEY_S     = 4'd2;
  localparam logic [IDX_W-1:0] KEY_D     = 4'd3;
  localparam logic [IDX_W-1:0] KEY_SPACE = 4'd4;
  localparam logic [IDX_W-1:0] KEY_ENTER = 4'd5;
  localparam logic [IDX_W-1:0] KEY_ESC   = 4'd6;
  localparam logic [IDX_W-1:0] KEY_UP    = 4'd7;
  localparam logic [IDX_W-1:0] KEY_DOWN  = 4'd8;
  localparam logic [IDX_W-1:0] KEY_LEFT  = 4'd9;
  localparam logic [IDX_W-1:0] KEY_RIGHT = 4'd10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ACK  = 2'd1,
    R_GAP  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational Set 2 lookup of {ext, byte} into a key bitmap index.
//   ext_i  : E0 prefix was seen before this byte
//   code_i : scan-code byte
//   hit_o  : byte maps to one of the tracked keys
//   idx_o  : bitmap index of that key (0 on a miss)
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic             ext_i,
  input  logic [7:0]       code_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    hit_o = 1'b1;
    idx_o = '0;
    case ({ext_i, code_i})
      {1'b0, SC_W}:     idx_o = KEY_W;
      {1'b0, SC_A}:     idx_o = KEY_A;
      {1'b0, SC_S}:     idx_o = KEY_S;
      {1'b0, SC_D}:     idx_o = KEY_D;
      {1'b0, SC_SPACE}: idx_o = KEY_SPACE;
      {1'b0, SC_ENTER}: idx_o = KEY_ENTER;
      {1'b0, SC_ESC}:   idx_o = KEY_ESC;
      {1'b1, SC_UP}:    idx_o = KEY_UP;
      {1'b1, SC_DOWN}:  idx_o = KEY_DOWN;
      {1'b1, SC_LEFT}:  idx_o = KEY_LEFT;
      {1'b1, SC_RIGHT}: idx_o = KEY_RIGHT;
      default:          hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Pops scan-code bytes from an upstream FIFO and maintains a held-key bitmap.
//   clk, clrn : clock, async active-low reset
//   kbd_data  : byte at FIFO head       kbd_ready : FIFO non-empty
//   kbd_rdn   : active-low pop strobe, one cycle per byte
//   keys      : held-key bitmap         key_event : one-cycle change pulse
//   key_index : changed bit index       key_break : 1 = release
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  output logic             kbd_rdn,
  output logic [NKEYS-1:0] keys,
  output logic             key_event,
  output logic [IDX_W-1:0] key_index,
  output logic             key_break
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  rd_state_e        state_q;
  logic [7:0]       byte_q;
  logic             rdn_q;
  logic [NKEYS-1:0] keys_q, keys_d;
  logic             event_q, chg_d;
  logic [IDX_W-1:0] index_q;
  logic             break_q;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             map_hit;
  logic [IDX_W-1:0] map_idx;
  logic             accept_c;
  logic             tmo_c;

  ps2_keymap u_keymap (
    .ext_i  (ext_q),
    .code_i (byte_q),
    .hit_o  (map_hit),
    .idx_o  (map_idx)
  );

  assign accept_c = (state_q == R_IDLE) && kbd_ready;

  // Prefix timeout: never fires in the cycle a byte is accepted or decoded
  assign tmo_c = (ext_q || brk_q) && !accept_c && (state_q != R_ACK) &&
                 (cnt_q == CNT_LAST);

  // Byte decode (R_ACK only) and prefix timeout
  always_comb begin
    keys_d = keys_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    chg_d  = 1'b0;
    if (state_q == R_ACK) begin
      case (byte_q)
        SC_E0: ext_d = 1'b1;
        SC_F0: brk_d = 1'b1;
        SC_00, SC_FF: begin
          keys_d = '0;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end
        SC_AA, SC_FA, SC_EE, SC_FE: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
        default: begin
          // Typematic repeats leave the bit unchanged and raise no event
          if (map_hit && (keys_q[map_idx] != !brk_q)) begin
            keys_d[map_idx] = !brk_q;
            chg_d           = 1'b1;
          end
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end else if (tmo_c) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  // Timeout counter: runs only while a prefix is pending between bytes
  always_comb begin
    cnt_d = '0;
    if ((ext_q || brk_q) && !accept_c && (state_q != R_ACK) && !tmo_c) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Read FSM, registered outputs and decode state
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= R_IDLE;
      byte_q  <= '0;
      rdn_q   <= 1'b1;
      keys_q  <= '0;
      event_q <= 1'b0;
      index_q <= '0;
      break_q <= 1'b0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      keys_q  <= keys_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      cnt_q   <= cnt_d;
      event_q <= chg_d;
      if (chg_d) begin
        index_q <= map_idx;
        break_q <= brk_q;
      end
      case (state_q)
        R_IDLE: begin
          if (kbd_ready) begin
            byte_q  <= kbd_data;
            rdn_q   <= 1'b0;
            state_q <= R_ACK;
          end
        end
        R_ACK: begin
          rdn_q   <= 1'b1;
          state_q <= R_GAP;
        end
        R_GAP:   state_q <= R_IDLE;
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign kbd_rdn   = rdn_q;
  assign keys      = keys_q;
  assign key_event = event_q;
  assign key_index = index_q;
  assign key_break = break_q;

endmodule
